// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared constants for the program loader.
//   ADDR_W / DATA_W : target memory word address and data widths
//   FRAME_W         : serial frame length, {data, addr}
//   ST_*            : FSM state encoding (3 bits, RUN needs the third bit)
package prog_loader_pkg;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = ADDR_W + DATA_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: host-side bus of the program loader.
//   wr_valid_in/wr_ready_out : write handshake for one memory word
//   wr_addr_in/wr_data_in    : target word address / data
//   wr_dmem_in               : 0 = instruction memory, 1 = data memory
//   run_start_in/run_len_in  : request a processor run of run_len_in cycles
// master = host, slave = loader.
interface prog_loader_if;
  import prog_loader_pkg::*;
  logic              wr_valid_in;
  logic              wr_ready_out;
  logic [ADDR_W-1:0] wr_addr_in;
  logic [DATA_W-1:0] wr_data_in;
  logic              wr_dmem_in;
  logic              run_start_in;
  logic [7:0]        run_len_in;

  modport master (output wr_valid_in, wr_addr_in, wr_data_in, wr_dmem_in,
                         run_start_in, run_len_in,
                  input  wr_ready_out);
  modport slave  (input  wr_valid_in, wr_addr_in, wr_data_in, wr_dmem_in,
                         run_start_in, run_len_in,
                  output wr_ready_out);
endinterface

// File: rtl/prog_loader_frame_piso.sv
// frame_piso: W-bit parallel-load, LSB-first shift register.
//   load  : capture din (has priority over shift)
//   shift : move one bit toward bit 0, zero fill at the top
//   lsb   : current bit 0, the next bit to go on the wire
module frame_piso #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         lsb
);
  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst)        sr <= '0;
    else if (load)  sr <= din;
    else if (shift) sr <= {1'b0, sr[W-1:1]};
  end

  assign lsb = sr[0];
endmodule

// File: rtl/prog_loader.sv
// prog_loader: serialises host memory words into a processor's instruction
// or data memory, then runs the processor for a requested number of cycles.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : host write / run request bus
//   csi_n_out    : instruction-memory chip select, active low
//   csd_n_out    : data-memory chip select, active low
//   mosi_out     : serial frame data, LSB first
//   proc_en_out  : processor run enable
//   busy_out     : loader not idle
//   done_out     : one-cycle pulse at the end of a run
// Frame timing: LEAD (cs low, mosi 0), then FRAME_W SHIFT cycles. The chip
// select is raised already in the last SHIFT cycle (the one carrying the
// frame MSB), so cs is low for exactly FRAME_W cycles. GAP_CYCLES idle
// cycles with both chip selects high follow every frame.
module prog_loader #(
  parameter int GAP_CYCLES = 2,
  parameter int FRAME_W    = prog_loader_pkg::FRAME_W
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus,
  output logic          csi_n_out,
  output logic          csd_n_out,
  output logic          mosi_out,
  output logic          proc_en_out,
  output logic          busy_out,
  output logic          done_out
);
  import prog_loader_pkg::*;

  localparam int CW = $clog2(FRAME_W);

  logic [2:0]    state;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    gap_cnt;
  logic [7:0]    run_cnt;
  logic          piso_bit;
  logic          wr_acc;
  logic          last_bit;

  assign bus.wr_ready_out = (state == ST_IDLE);
  assign wr_acc   = bus.wr_valid_in && (state == ST_IDLE);
  assign last_bit = (bit_cnt == CW'(FRAME_W - 1));

  // Bit 0 is consumed on the LEAD->SHIFT edge, so the register shifts in LEAD
  // and in every SHIFT cycle except the last.
  frame_piso #(.W(FRAME_W)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (wr_acc),
    .shift ((state == ST_LEAD) || (state == ST_SHIFT && !last_bit)),
    .din   (FRAME_W'({bus.wr_data_in, bus.wr_addr_in})),
    .lsb   (piso_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      csi_n_out   <= 1'b1;
      csd_n_out   <= 1'b1;
      mosi_out    <= 1'b0;
      proc_en_out <= 1'b0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      run_cnt     <= '0;
    end else begin
      done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.wr_valid_in) begin
            // write wins over a simultaneous run request
            state     <= ST_LEAD;
            busy_out  <= 1'b1;
            csi_n_out <= bus.wr_dmem_in;
            csd_n_out <= !bus.wr_dmem_in;
            mosi_out  <= 1'b0;
          end else if (bus.run_start_in) begin
            if (bus.run_len_in == 8'd0) begin
              done_out <= 1'b1;
            end else begin
              state       <= ST_RUN;
              busy_out    <= 1'b1;
              proc_en_out <= 1'b1;
              run_cnt     <= bus.run_len_in;
            end
          end
        end
        ST_LEAD: begin
          state    <= ST_SHIFT;
          mosi_out <= piso_bit;
          bit_cnt  <= '0;
        end
        ST_SHIFT: begin
          if (last_bit) begin
            state    <= ST_GAP;
            mosi_out <= 1'b0;
            gap_cnt  <= 4'(GAP_CYCLES - 1);
          end else begin
            bit_cnt  <= bit_cnt + 1'b1;
            mosi_out <= piso_bit;
            if (bit_cnt == CW'(FRAME_W - 2)) begin
              csi_n_out <= 1'b1;
              csd_n_out <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'd0) begin
            state    <= ST_IDLE;
            busy_out <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        ST_RUN: begin
          // exit on the last enabled cycle; the counter never goes below 1
          if (run_cnt <= 8'd1) begin
            state       <= ST_IDLE;
            busy_out    <= 1'b0;
            proc_en_out <= 1'b0;
            done_out    <= 1'b1;
            run_cnt     <= 8'd0;
          end else begin
            run_cnt <= run_cnt - 8'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end
endmodule
